// File: rtl/dsc_mul_6b.sv
// dsc_mul_6b: deterministic stochastic-computing unsigned multiplier, z = a*b.
// Stream A compares a against a free-running counter; stream B compares b
// against a counter that steps once per wrap of the first one. Counting the
// cycles where both streams are high over the full 2^(2N) cycle sweep yields
// exactly a*b.
// Optional feature: define DSC_MUL_EARLY_DONE_EN to finish as soon as the
// remaining rows of the sweep can no longer contribute to the product.

// Plain WIDTH-bit up-counter with a wrap (overflow) flag.
module dsc_mul_6b_ctr #(
  parameter int WIDTH = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: increment (natural wrap to zero) only when asked to.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = inc_i && (cnt_q == {WIDTH{1'b1}});

endmodule

module dsc_mul_6b #(
  parameter int N = 6
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           en_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [2*N-1:0] z_o,
  output logic           ov_o
);

  logic [N-1:0]   ctrA;
  logic [N-1:0]   ctrB;
  logic           wrapA;
  logic           wrapB;
  logic           step;
  logic           streamA;
  logic           streamB;
  logic           done;
  logic [2*N-1:0] z_q;
  logic [2*N-1:0] z_d;
  logic           ov_q;
  logic           ov_d;

  // The sweep advances only while enabled and not yet finished.
  assign step = en_i && !ov_q;

  // Column counter: runs on every advancing cycle.
  dsc_mul_6b_ctr #(.WIDTH(N)) uCtrA (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (step),
    .cnt_o  (ctrA),
    .wrap_o (wrapA)
  );

  // Row counter: steps once per column-counter wrap; its wrap marks the sweep end.
  dsc_mul_6b_ctr #(.WIDTH(N)) uCtrB (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (wrapA),
    .cnt_o  (ctrB),
    .wrap_o (wrapB)
  );

  // Unary bitstreams and the completion condition for the current edge.
  always_comb begin
    streamA = (a_i > ctrA);
    streamB = (b_i > ctrB);
`ifdef DSC_MUL_EARLY_DONE_EN
    // Rows at or beyond b never have stream B high, so the last useful row is b-1.
    done = wrapB || (wrapA && ((b_i == '0) || (ctrB >= (b_i - N'(1)))));
`else
    done = wrapB;
`endif
  end

  // Accumulator and sticky finish flag next-state.
  always_comb begin
    z_d  = z_q;
    ov_d = ov_q;
    if (step) begin
      if (streamA && streamB) begin
        z_d = z_q + (2*N)'(1);
      end
      if (done) begin
        ov_d = 1'b1;
      end
    end
  end

  // Accumulator and finish flag registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      z_q  <= '0;
      ov_q <= 1'b0;
    end else begin
      z_q  <= z_d;
      ov_q <= ov_d;
    end
  end

  assign z_o  = z_q;
  assign ov_o = ov_q;

endmodule

// File: tb/tb_dsc_mul_6b.sv
// tb_dsc_mul_6b: directed and a few random operand pairs for dsc_mul_6b.
// Expected products are queued when a run is launched; a monitor pops and
// compares whenever the DUT raises ov. Honours DSC_MUL_EARLY_DONE_EN for latency.
module tb_dsc_mul_6b;

  logic        clk;
  logic        rst;
  logic        en;
  logic [5:0]  a;
  logic [5:0]  b;
  logic [11:0] z;
  logic        ov;

  int vectorCount = 0;
  int missCount   = 0;
  logic [11:0] expQ [$];
  logic ovPrev = 1'b0;

  dsc_mul_6b #(.N(6)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (en),
    .a_i   (a),
    .b_i   (b),
    .z_o   (z),
    .ov_o  (ov)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared comparison: counts every check, reports failures.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expV);
    vectorCount++;
    if (act !== expV) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expV, $time);
    end
  endtask

  // Enabled edges needed before ov rises for a given b.
  function automatic int expLatency(input logic [5:0] bV);
`ifdef DSC_MUL_EARLY_DONE_EN
    return 64 * ((bV == 6'd0) ? 1 : int'(bV));
`else
    return 4096 + 0 * int'(bV);
`endif
  endfunction

  // Scoreboard monitor: on each ov rising edge compare z with the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (ov === 1'b1 && ovPrev !== 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedOv", 32'(z), 32'hFFFF_FFFF);
        end else begin
          checkOutput("product", 32'(z), 32'(expQ.pop_front()));
        end
      end
      ovPrev = ov;
    end
  end

  // One full operation: reset, launch, optional en gap, wait for ov, optional hold.
  task automatic applyStimulus(input logic [5:0] aV, input logic [5:0] bV,
                               input int gapAt, input int gapLen, input int holdCycles);
    int edges;
    int lat;
    bit done;
    logic [11:0] prod;
    prod = 12'(aV) * 12'(bV);
    lat  = expLatency(bV);
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    a   = aV;
    b   = bV;
    @(negedge clk);
    checkOutput("resetZ", 32'(z), 32'd0);
    checkOutput("resetOv", 32'(ov), 32'd0);
    expQ.push_back(prod);
    rst   = 1'b0;
    edges = 0;
    done  = 1'b0;
    while (!done && edges < lat + gapLen + 64) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (ov === 1'b1) begin
        done = 1'b1;
      end else if (gapLen > 0 && edges == gapAt) begin
        en = 1'b0;
        repeat (gapLen) begin
          @(posedge clk);
          edges++;
          @(negedge clk);
        end
        en = 1'b1;
      end
    end
    checkOutput("ovTimeout", 32'(done), 32'd1);
    checkOutput("latency", 32'(edges), 32'(lat + gapLen));
    // Keep en high and disturb operands; result must stay frozen.
    for (int i = 0; i < holdCycles; i++) begin
      a = 6'(i);
      b = 6'(63 - i);
      @(negedge clk);
      checkOutput("holdZ", 32'(z), 32'(prod));
      checkOutput("holdOv", 32'(ov), 32'd1);
    end
  endtask

  // Directed sequence, asynchronous-reset abort, and a few random operands.
  initial begin
    logic [5:0] ra;
    logic [5:0] rb;
    int waitCnt;
    rst = 1'b1;
    en  = 1'b0;
    a   = 6'd0;
    b   = 6'd0;
    repeat (2) @(negedge clk);
    checkOutput("initZ", 32'(z), 32'd0);
    checkOutput("initOv", 32'(ov), 32'd0);

    applyStimulus(6'd15, 6'd15, 0, 0, 0);
    applyStimulus(6'd63, 6'd63, 0, 0, 100);
    applyStimulus(6'd0, 6'd37, 0, 0, 0);
    applyStimulus(6'd37, 6'd0, 0, 0, 0);
    applyStimulus(6'd21, 6'd50, 300, 7, 0);

    // Abort mid-operation with an asynchronous reset between edges.
    @(negedge clk);
    rst = 1'b1;
    a   = 6'd40;
    b   = 6'd40;
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    repeat (1000) @(posedge clk);
    #3;
    checkOutput("midRunZNonZero", 32'(z != 12'd0), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("asyncRstZ", 32'(z), 32'd0);
    checkOutput("asyncRstOv", 32'(ov), 32'd0);
    applyStimulus(6'd5, 6'd9, 0, 0, 0);

    for (int r = 0; r < 4; r++) begin
      ra = 6'($urandom_range(0, 63));
      rb = 6'($urandom_range(0, 63));
      applyStimulus(ra, rb, 0, 0, 0);
    end

    // Give the monitor a bounded chance to drain the scoreboard.
    waitCnt = 0;
    while (expQ.size() != 0 && waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
